hex_entry_pad: RTL and testbench

//  Front-panel hex entry: the input-side producer of the 16-bit value the hex display driver shows.
//  - Debounces five pushbuttons, turns presses into one-cycle pulses.
//  - Edits a 4-nibble buffer digit by digit; commits it on Enter.
//  - Outputs a display value and a blink mask for the 4-digit 7-seg driver.

---
 rtl/hex_entry_pad_pkg.sv | 34 +++
 rtl/hex_entry_pad_debounce.sv | 59 +++++
 rtl/hex_entry_pad.sv | 193 +++++++++++++++++++
 tb/tb_hex_entry_pad.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pad_pkg.sv
// Shared types and constants for the hex entry pad.
// States, button indices and a nibble-edit helper used by the top level.
package hex_entry_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NUM_BTNS  = 5;
  localparam int NIBBLES   = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;

  // Increment or decrement one nibble modulo 16 without touching its neighbours.
  function automatic logic [NIBBLES*4-1:0] step_nibble(
    input logic [NIBBLES*4-1:0] value,
    input logic [1:0]           idx,
    input logic                 inc
  );
    logic [NIBBLES*4-1:0] result;
    logic [3:0]           nib;
    result = value;
    nib    = value[idx*4 +: 4];
    result[idx*4 +: 4] = inc ? (nib + 4'd1) : (nib - 4'd1);
    return result;
  endfunction

endpackage

// File: rtl/hex_entry_pad_debounce.sv
// Per-button input conditioning: 2-FF synchroniser, stability counter,
// debounced level and a one-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has disagreed with the old one for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/hex_entry_pad.sv
// Front-panel hex entry: debounced buttons edit a 4-nibble buffer that is
// committed to value_out on Enter; drives a display value and blink mask.
// Optional feature macro: AUTO_REPEAT_EN (hold up/down to auto-repeat in EDIT).
module hex_entry_pad
  import hex_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_CYCLES    = 25_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_enter,
  output logic [15:0] display_value,
  output logic [3:0]  digit_blank,
  output logic [15:0] value_out,
  output logic        value_valid,
  output logic        editing,
  output logic [1:0]  cursor
);

  localparam int BL_W = $clog2(BLINK_CYCLES);

  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_press;
  logic [NUM_BTNS-1:0] w_level;
  logic                w_up;
  logic                w_down;
  logic                w_unused_lvl;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_edit_buf;
  logic [15:0] w_next_buf;
  logic [15:0] r_value_out;
  logic        r_value_valid;
  logic [1:0]  r_cursor;
  logic [1:0]  w_next_cursor;
  logic        w_blink_restart;
  logic        w_commit;
  logic [BL_W-1:0] r_blink_cnt;
  logic        r_blink_off;

  assign w_raw[BTN_UP]    = btn_up;
  assign w_raw[BTN_DOWN]  = btn_down;
  assign w_raw[BTN_LEFT]  = btn_left;
  assign w_raw[BTN_RIGHT] = btn_right;
  assign w_raw[BTN_ENTER] = btn_enter;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (w_raw[g]),
      .o_level(w_level[g]),
      .o_press(w_press[g])
    );
  end

  // Only the up/down levels feed the repeat logic; the rest are informational.
  assign w_unused_lvl = ^w_level;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             w_rep_hold;
  logic             w_rep_fire;

  assign w_rep_hold = (r_state == EDIT) && (w_level[BTN_UP] || w_level[BTN_DOWN]);
  assign w_rep_fire = w_rep_hold && (r_rep_cnt == REP_W'(REPEAT_DELAY));

  // Count hold time; after the first repeat, rewind so the next fires REPEAT_PERIOD later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (!w_rep_hold) begin
      r_rep_cnt <= '0;
    end else if (w_rep_fire) begin
      r_rep_cnt <= REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    end else begin
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
    end
  end

  assign w_up   = w_press[BTN_UP]   | (w_rep_fire & w_level[BTN_UP]);
  assign w_down = w_press[BTN_DOWN] | (w_rep_fire & w_level[BTN_DOWN]);
`else
  logic w_unused_rep;

  assign w_unused_rep = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_up         = w_press[BTN_UP];
  assign w_down       = w_press[BTN_DOWN];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and buffer/cursor edits; one action per cycle, enter > up > down > left > right.
  always_comb begin
    w_next_state    = r_state;
    w_next_buf      = r_edit_buf;
    w_next_cursor   = r_cursor;
    w_blink_restart = 1'b0;
    w_commit        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press[BTN_ENTER]) begin
          w_next_state    = EDIT;
          w_next_buf      = r_value_out;
          w_next_cursor   = 2'd0;
          w_blink_restart = 1'b1;
        end
      end
      EDIT: begin
        if (w_press[BTN_ENTER]) begin
          w_next_state = COMMIT;
        end else if (w_up) begin
          w_next_buf = step_nibble(r_edit_buf, r_cursor, 1'b1);
        end else if (w_down) begin
          w_next_buf = step_nibble(r_edit_buf, r_cursor, 1'b0);
        end else if (w_press[BTN_LEFT]) begin
          w_next_cursor   = r_cursor + 2'd1;
          w_blink_restart = 1'b1;
        end else if (w_press[BTN_RIGHT]) begin
          w_next_cursor   = r_cursor - 2'd1;
          w_blink_restart = 1'b1;
        end
      end
      COMMIT: begin
        w_next_state = IDLE;
        w_commit     = 1'b1;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Edit buffer, cursor and committed value; valid pulses alongside the new value_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edit_buf    <= '0;
      r_cursor      <= '0;
      r_value_out   <= '0;
      r_value_valid <= 1'b0;
    end else begin
      r_edit_buf    <= w_next_buf;
      r_cursor      <= w_next_cursor;
      r_value_valid <= w_commit;
      if (w_commit) begin
        r_value_out <= r_edit_buf;
      end
    end
  end

  // Cursor blink timer: idle outside EDIT, restarted in the on phase by entry or cursor moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if ((r_state != EDIT) || w_blink_restart) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + BL_W'(1);
    end
  end

  assign editing       = (r_state == EDIT);
  assign display_value = editing ? r_edit_buf : r_value_out;
  assign digit_blank   = (editing && r_blink_off) ? (4'b0001 << r_cursor) : 4'b0000;
  assign value_out     = r_value_out;
  assign value_valid   = r_value_valid;
  assign cursor        = r_cursor;

endmodule

// File: tb/tb_hex_entry_pad.sv
// Self-checking bench for hex_entry_pad with small timing parameters.
// A cycle-level reference model tracks value, nibbles, cursor and blink age;
// define AUTO_REPEAT_EN to also exercise the auto-repeat hold sequence.
module tb_hex_entry_pad;

  localparam int DEB     = 4;
  localparam int BLINK   = 8;
  localparam int RDELAY  = 20;
  localparam int RPERIOD = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnUp = 1'b0;
  logic        btnDown = 1'b0;
  logic        btnLeft = 1'b0;
  logic        btnRight = 1'b0;
  logic        btnEnter = 1'b0;
  logic [15:0] display_value;
  logic [3:0]  digit_blank;
  logic [15:0] value_out;
  logic        value_valid;
  logic        editing;
  logic [1:0]  cursor;

  hex_entry_pad #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLINK),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPERIOD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up       (btnUp),
    .btn_down     (btnDown),
    .btn_left     (btnLeft),
    .btn_right    (btnRight),
    .btn_enter    (btnEnter),
    .display_value(display_value),
    .digit_blank  (digit_blank),
    .value_out    (value_out),
    .value_valid  (value_valid),
    .editing      (editing),
    .cursor       (cursor)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  localparam logic [4:0] M_UP    = 5'b00001;
  localparam logic [4:0] M_DOWN  = 5'b00010;
  localparam logic [4:0] M_LEFT  = 5'b00100;
  localparam logic [4:0] M_RIGHT = 5'b01000;
  localparam logic [4:0] M_ENTER = 5'b10000;

  int testsRun = 0;
  int failCount = 0;
  int cycle = 0;
  int lastStart = 0;
  int riseCycle = 0;
  int validCount = 0;
  logic prevEditing = 1'b0;

  logic [15:0] mValue;
  logic [3:0]  mNib [4];
  logic [1:0]  mCursor;
  logic        mEditing;
  logic        mCommitPending;
  logic        mValid;
  int          mAge;
  int          actQ [$];
  logic [4:0]  actMask;

  function automatic logic [15:0] packNibs();
    return {mNib[3], mNib[2], mNib[1], mNib[0]};
  endfunction

  task automatic modelReset();
    mValue = 16'h0000;
    for (int i = 0; i < 4; i++) mNib[i] = 4'h0;
    mCursor = 2'd0;
    mEditing = 1'b0;
    mCommitPending = 1'b0;
    mValid = 1'b0;
    mAge = 0;
    actQ.delete();
  endtask

  task automatic modelAction(input logic [4:0] m);
    if (!mEditing) begin
      if (m[4]) begin
        mEditing = 1'b1;
        for (int i = 0; i < 4; i++) mNib[i] = mValue[i*4 +: 4];
        mCursor = 2'd0;
        mAge = 0;
      end
    end else if (m[4]) begin
      mEditing = 1'b0;
      mCommitPending = 1'b1;
    end else if (m[0]) begin
      mNib[mCursor] = mNib[mCursor] + 4'd1;
    end else if (m[1]) begin
      mNib[mCursor] = mNib[mCursor] - 4'd1;
    end else if (m[2]) begin
      mCursor = mCursor + 2'd1;
      mAge = 0;
    end else if (m[3]) begin
      mCursor = mCursor - 2'd1;
      mAge = 0;
    end
  endtask

  task automatic modelStep();
    mValid = 1'b0;
    if (mCommitPending) begin
      mValue = packNibs();
      mValid = 1'b1;
      mCommitPending = 1'b0;
    end
    if (mEditing) mAge++;
    while (actQ.size() > 0 && actQ[0] == cycle) begin
      void'(actQ.pop_front());
      modelAction(actMask);
    end
  endtask

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [15:0] expDisp;
    logic [3:0]  expBlank;
    expDisp  = mEditing ? packNibs() : mValue;
    expBlank = (mEditing && ((mAge / BLINK) % 2 == 1)) ? (4'b0001 << mCursor) : 4'b0000;
    checkVal("display_value", display_value, expDisp);
    checkVal("digit_blank", 16'(digit_blank), 16'(expBlank));
    checkVal("value_out", value_out, mValue);
    checkVal("value_valid", 16'(value_valid), 16'(mValid));
    checkVal("editing", 16'(editing), 16'(mEditing));
    checkVal("cursor", 16'(cursor), 16'(mCursor));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    modelStep();
    checkOutput();
    if (value_valid) validCount++;
    if (editing && !prevEditing) riseCycle = cycle;
    prevEditing = editing;
  endtask

  task automatic setBtns(input logic [4:0] m);
    btnUp    = m[0];
    btnDown  = m[1];
    btnLeft  = m[2];
    btnRight = m[3];
    btnEnter = m[4];
  endtask

  // Hold the buttons in mask for 'hold' cycles, release, then let things settle.
  task automatic applyStimulus(input logic [4:0] mask, input int hold, input int settle);
    int start;
    start = cycle;
    lastStart = start;
    actMask = mask;
    if (hold >= DEB) begin
      actQ.push_back(start + DEB + 3);
`ifdef AUTO_REPEAT_EN
      if ((mask[0] || mask[1]) && mEditing && !mask[4]) begin
        for (int f = start + DEB + 2 + RDELAY; f <= start + hold + DEB + 1; f += RPERIOD)
          actQ.push_back(f + 1);
      end
`endif
    end
    setBtns(mask);
    repeat (hold) tick();
    setBtns(5'b00000);
    repeat (settle) tick();
  endtask

  task automatic press(input logic [4:0] mask);
    applyStimulus(mask, 6, 8);
  endtask

  task automatic asyncReset();
    rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput();
    #2;
    rst_n = 1'b1;
  endtask

  logic [15:0] target;
  logic [1:0]  curBefore;
  logic [3:0]  nibBefore;
  int          r;
  logic [4:0]  mask;

  initial begin
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // Short enter glitch must leave everything idle.
    applyStimulus(M_ENTER, 3, 10);
    checkVal("glitch_editing", 16'(editing), 16'd0);

    // Enter held 10 cycles: editing rises exactly 2+4+1 clocks after the raw edge.
    applyStimulus(M_ENTER, 10, 8);
    checkVal("enter_latency", 16'(riseCycle - lastStart), 16'd7);

    // up x3, left, up x15, enter -> 0x00F3 with one valid pulse.
    repeat (3) press(M_UP);
    press(M_LEFT);
    repeat (15) press(M_UP);
    press(M_ENTER);
    checkVal("commit_value", value_out, 16'h00F3);
    checkVal("valid_pulses", 16'(validCount), 16'd1);
    checkVal("commit_editing", 16'(editing), 16'd0);

    // Cursor and nibble wrap-around.
    press(M_ENTER);
    press(M_RIGHT);
    checkVal("cursor_wrap", 16'(cursor), 16'd3);
    press(M_DOWN);
    checkVal("nibble_wrap_down", display_value, 16'hF0F3);
    press(M_RIGHT);
    press(M_DOWN);
    press(M_RIGHT);
    press(M_RIGHT);
    repeat (4) press(M_DOWN);
    checkVal("all_f", display_value, 16'hFFFF);
    press(M_UP);
    checkVal("lsd_wrap_up", display_value, 16'hFFF0);

    // Move to cursor 2 and watch the blink, then move again mid-off-phase.
    press(M_LEFT);
    press(M_LEFT);
    checkVal("blink_cursor", 16'(cursor), 16'd2);
    applyStimulus(5'b00000, 0, 20);
    press(M_LEFT);
    press(M_RIGHT);

    // Simultaneous up+left: nibble increments, cursor stays.
    curBefore = mCursor;
    press(M_UP | M_LEFT);
    checkVal("simul_cursor", 16'(cursor), 16'(curBefore));

`ifdef AUTO_REPEAT_EN
    // Holding up 40 cycles past debounce yields 1 + 1 + 4 increments.
    nibBefore = mNib[mCursor];
    applyStimulus(M_UP, 42, 10);
    checkVal("repeat_count", 16'(display_value[mCursor*4 +: 4] - nibBefore), 16'd6);
`endif

    // Build 0x1234 in the edit buffer, then reset mid-edit.
    target = 16'h1234;
    for (int i = 3; i >= 0; i--) begin
      while (mCursor != 2'(i)) press(M_LEFT);
      while (mNib[i] != target[i*4 +: 4]) press(M_UP);
    end
    checkVal("buf_1234", display_value, 16'h1234);
    validCount = 0;
    asyncReset();
    repeat (10) tick();
    checkVal("reset_value", value_out, 16'h0000);
    checkVal("reset_editing", 16'(editing), 16'd0);
    checkVal("reset_no_valid", 16'(validCount), 16'd0);

    // Randomised button traffic against the model.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        press(5'(1 << r));
      end else if (r <= 6) begin
        mask = 5'(1 << $urandom_range(0, 4)) | 5'(1 << $urandom_range(0, 4));
        press(mask);
      end else if (r == 7) begin
        applyStimulus(5'(1 << $urandom_range(0, 4)), $urandom_range(1, 3), 8);
      end else begin
        press(M_ENTER);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
